write_channel_arbiter: RTL and testbench
========================================

// Module: write_channel_arbiter
// PURPOSE
//  Shares one write_channel_axi frontend (IOb valid/addr/wdata/wstrb/ready)
//  between N_REQ write requesters, e.g. write-through buffer and victim path.
//  Round-robin grant; one write in flight; payload registered and held stable.
//  Sits between the cache write sources and the AXI write channel module.
//  Also provides a sticky response-timeout flag.
// PARAMETERS
//  N_REQ      2   number of requesters (>=2)
//  ADDR_W     32  byte-address width, passed through unchanged
//  DATA_W     32  write data width
//  NBYTES     DATA_W/8  strobe width
//  GNT_W      $clog2(N_REQ)  grant index width
//  TIMEOUT_W  10  WAIT-cycle watchdog counter width
// PORTS
//  ap_clk     in   1               clock
//  reset      in   1               async active-high reset
//  req_valid  in   N_REQ           request per requester, held until req_ready
//  req_addr   in   N_REQ*ADDR_W    packed addresses; requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   N_REQ*DATA_W    packed write data
//  req_wstrb  in   N_REQ*NBYTES    packed byte strobes
//  req_ready  out  N_REQ           one-cycle completion pulse to granted requester
//  m_valid    out  1               downstream request, one-cycle pulse
//  m_addr     out  ADDR_W          registered address of granted request
//  m_wdata    out  DATA_W          registered data
//  m_wstrb    out  NBYTES          registered strobes
//  m_ready    in   1               downstream idle (IDLE) / write-done (WAIT)
//  busy       out  1               state != IDLE
//  grant_id   out  GNT_W           index of current/last granted requester
//  timeout_err out 1               sticky: WAIT lasted 2**TIMEOUT_W-1 cycles
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, wdog=0.
//   All outputs 0, including the m_addr/m_wdata/m_wstrb registers.
//  States: IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE:
//   - Grant only if m_ready=1 and |req_valid.
//   - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - On grant: latch winner's addr/wdata/wstrb into m_*; grant_id<=winner; go ISSUE.
//  ISSUE:
//   - m_valid=1 for exactly this cycle; go WAIT unconditionally.
//   - Latency: req_valid sampled in cycle T gives m_valid in cycle T+1.
//  WAIT:
//   - m_valid=0. m_ready is not sampled in the first WAIT cycle; the downstream
//     ready there reflects its leaving idle.
//   - From the second WAIT cycle on, m_ready=1 means complete:
//     req_ready[grant_id]=1 that cycle, rr_ptr<=(grant_id+1) mod N_REQ, go IDLE.
//  req_ready is combinational from state/m_ready; it is one-hot or zero,
//   and never asserted outside WAIT.
//  m_addr/m_wdata/m_wstrb change only on a grant; they stay stable through ISSUE and WAIT.
//  Requests:
//   - Withdrawing req_valid before grant is legal; the request is simply not seen.
//   - After grant, req_* changes are ignored until completion.
//   - wstrb=0 requests are forwarded unchanged.
//  Back-to-back: completion and the next grant never share a cycle.
//   The next grant is earliest in the following IDLE cycle.
//  Watchdog (wdog):
//   - Clears on entering WAIT; increments each WAIT cycle, saturating at all-ones.
//   - At all-ones, timeout_err<=1 and stays 1 until reset.
//   - No abort: the arbiter keeps waiting.
//  grant_id holds its last value while IDLE.
//  Reset mid-transaction: abandoned, no req_ready pulse.
//   The downstream shares reset, so no AXI state leaks.
// TESTING
//  1. Only req0 valid: addr=0x100, wdata=0xDEADBEEF, wstrb=0xF, m_ready=1.
//     -> m_valid pulse next cycle with exactly those values.
//     -> m_ready low 3 cycles then high -> single req_ready=2'b01 pulse.
//  2. req0 and req1 both held valid after reset.
//     -> grants in order 0,1,0,1; grant_id matches; one transaction at a time.
//  3. m_ready=0 in IDLE with req1 valid -> no m_valid, busy=0.
//     -> m_ready rises -> grant to 1 next cycle.
//  4. TIMEOUT_W=4, m_ready held 0 in WAIT -> timeout_err=1 after 15 WAIT cycles.
//     -> m_ready later 1 -> completion still signalled; timeout_err stays 1.
//  5. reset pulsed during WAIT -> all outputs 0, busy=0.
//     -> after release, req1-only request granted normally.
//  6. req0 asserted then dropped while a req1 write is in WAIT.
//     -> after completion req0 is not granted; m_valid stays 0.

Source files
------------

// File: rtl/write_channel_arbiter.sv
// write_channel_arbiter
//   Shares one AXI write-channel frontend (IOb-style valid/addr/wdata/wstrb/
//   ready) between N_REQ write sources, e.g. the write-through buffer and
//   the victim path. Round-robin grant, one write in flight, and the granted
//   payload is registered and held stable until completion. A sticky flag
//   reports a WAIT phase that ran for 2**TIMEOUT_W-1 cycles.
//
// Ports
//   ap_clk, reset     clock, asynchronous active-high reset
//   req_valid[i]      request from requester i, held until req_ready[i]
//   req_addr/wdata/wstrb  packed payloads, requester i in slice i
//   req_ready[i]      one-cycle completion pulse to the granted requester
//   m_valid           one-cycle request pulse to the downstream channel
//   m_addr/wdata/wstrb    registered payload of the granted request
//   m_ready           downstream idle (IDLE) / write done (WAIT)
//   busy              a transaction is in progress
//   grant_id          index of the current / last granted requester
//   timeout_err       sticky watchdog flag, cleared only by reset
module write_channel_arbiter #(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NBYTES    = DATA_W / 8,
    parameter int GNT_W     = $clog2(N_REQ),
    parameter int TIMEOUT_W = 10
) (
    input  logic                     ap_clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    input  logic [N_REQ*NBYTES-1:0]  req_wstrb,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     m_valid,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [NBYTES-1:0]        m_wstrb,
    input  logic                     m_ready,
    output logic                     busy,
    output logic [GNT_W-1:0]         grant_id,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;
    // One below saturation: the increment out of this value reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] WDOG_PRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GNT_W-1:0]       r_rr_ptr;
    logic [GNT_W-1:0]       r_grant_id;
    logic [ADDR_W-1:0]      r_m_addr;
    logic [DATA_W-1:0]      r_m_wdata;
    logic [NBYTES-1:0]      r_m_wstrb;
    logic                   r_wait_first;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic                   r_timeout;

    logic                   w_found;
    logic [GNT_W-1:0]       w_winner;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_wdata;
    logic [NBYTES-1:0]      w_wstrb;
    logic                   w_grant;
    logic                   w_done;

    // (base + k) mod N_REQ, with base < N_REQ and k < N_REQ.
    function automatic logic [GNT_W-1:0] rr_idx(input logic [GNT_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return GNT_W'(s);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[rr_idx(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = rr_idx(r_rr_ptr, k);
            end
        end
    end

    // Payload select for the winner
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (GNT_W'(i) == w_winner) begin
                w_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_wstrb = req_wstrb[i*NBYTES +: NBYTES];
            end
        end
    end

    // Grant needs the downstream to be idle. Completion ignores the first
    // WAIT cycle, where m_ready still shows the downstream leaving idle.
    assign w_grant = (r_state == S_IDLE) && m_ready && w_found;
    assign w_done  = (r_state == S_WAIT) && !r_wait_first && m_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        m_valid     = 1'b0;
        busy        = 1'b1;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_grant) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                m_valid     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                    for (int i = 0; i < N_REQ; i++)
                        req_ready[i] = (r_grant_id == GNT_W'(i));
                end
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_wstrb  <= '0;
        end else begin
            if (w_grant) begin
                r_grant_id <= w_winner;
                r_m_addr   <= w_addr;
                r_m_wdata  <= w_wdata;
                r_m_wstrb  <= w_wstrb;
            end
            // Next search starts just past the requester that completed.
            if (w_done)
                r_rr_ptr <= (r_grant_id == GNT_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // First-WAIT marker and watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            r_wait_first <= 1'b0;
            r_wdog       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_wait_first <= (r_state == S_ISSUE);
            if (r_state == S_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT) begin
                if (r_wdog != WDOG_MAX) r_wdog <= r_wdog + 1'b1;
                // Flag at the same edge the counter saturates; sticky after.
                if (r_wdog == WDOG_PRE || r_wdog == WDOG_MAX) r_timeout <= 1'b1;
            end
        end
    end

    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign m_wstrb     = r_m_wstrb;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_write_channel_arbiter.sv
module tb_write_channel_arbiter;

    localparam int N_REQ     = 2;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int NBYTES    = 4;
    localparam int GNT_W     = 1;
    localparam int TIMEOUT_W = 4;

    logic                     ap_clk = 1'b0;
    logic                     reset  = 1'b1;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ*ADDR_W-1:0]  req_addr  = '0;
    logic [N_REQ*DATA_W-1:0]  req_wdata = '0;
    logic [N_REQ*NBYTES-1:0]  req_wstrb = '0;
    logic [N_REQ-1:0]         req_ready;
    logic                     m_valid;
    logic [ADDR_W-1:0]        m_addr;
    logic [DATA_W-1:0]        m_wdata;
    logic [NBYTES-1:0]        m_wstrb;
    logic                     m_ready = 1'b0;
    logic                     busy;
    logic [GNT_W-1:0]         grant_id;
    logic                     timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    write_channel_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NBYTES(NBYTES),
        .GNT_W(GNT_W), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .ap_clk(ap_clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_ready(req_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic step(input int n = 1);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
        req_wstrb[i*NBYTES +: NBYTES] = s;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        m_ready   = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        step(2);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wstrb", m_wstrb, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 1'b0;
        step(1);

        // ---------------- 1: single requester ----------------
        set_req(0, 32'h100, 32'hDEADBEEF, 4'hF);
        set_req(1, 32'h999, 32'h99999999, 4'h5);
        req_valid = 2'b01;
        m_ready   = 1'b1;
        step();
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_addr", m_addr, 32'h100);
        chk("t1_m_wdata", m_wdata, 32'hDEADBEEF);
        chk("t1_m_wstrb", m_wstrb, 4'hF);
        chk("t1_grant_id", grant_id, 0);
        chk("t1_busy", busy, 1);
        m_ready = 1'b0;
        step();
        chk("t1_wait1_m_valid", m_valid, 0);
        chk("t1_wait1_ready", req_ready, 0);
        step(2);
        chk("t1_wait3_ready", req_ready, 0);
        chk("t1_wait3_busy", busy, 1);
        m_ready = 1'b1;
        #1;
        chk("t1_done_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        step();
        chk("t1_idle_ready", req_ready, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_m_valid", m_valid, 0);
        chk("t1_hold_addr", m_addr, 32'h100);
        step();
        chk("t1_no_regrant", m_valid, 0);

        // ---------------- 2: round robin 0,1,0,1 ----------------
        do_reset();
        set_req(0, 32'hA00, 32'h11111111, 4'h3);
        set_req(1, 32'hB00, 32'h22222222, 4'h0);
        req_valid = 2'b11;
        m_ready   = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("t2_m_valid", m_valid, 1);
            chk("t2_grant_id", grant_id, t % 2);
            chk("t2_m_addr", m_addr, (t % 2) ? 32'hB00 : 32'hA00);
            chk("t2_m_wstrb", m_wstrb, (t % 2) ? 4'h0 : 4'h3);
            step();
            chk("t2_wait1_ready", req_ready, 0);
            chk("t2_wait1_m_valid", m_valid, 0);
            step();
            chk("t2_done_ready", req_ready, (t % 2) ? 2'b10 : 2'b01);
            step();
            chk("t2_idle_busy", busy, 0);
        end
        req_valid = 2'b00;

        // ---------------- 3: downstream not ready in IDLE ----------------
        do_reset();
        m_ready   = 1'b0;
        req_valid = 2'b10;
        step(3);
        chk("t3_held_m_valid", m_valid, 0);
        chk("t3_held_busy", busy, 0);
        m_ready = 1'b1;
        step();
        chk("t3_m_valid", m_valid, 1);
        chk("t3_grant_id", grant_id, 1);
        chk("t3_m_addr", m_addr, 32'hB00);
        step(2);
        chk("t3_done_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        step();

        // ---------------- 4: watchdog ----------------
        do_reset();
        req_valid = 2'b01;
        m_ready   = 1'b1;
        step();
        chk("t4_m_valid", m_valid, 1);
        m_ready = 1'b0;
        step();       // WAIT cycle 1
        step(14);     // WAIT cycle 15
        chk("t4_wait15_timeout", timeout_err, 0);
        step();       // WAIT cycle 16
        chk("t4_wait16_timeout", timeout_err, 1);
        chk("t4_still_busy", busy, 1);
        chk("t4_no_ready", req_ready, 0);
        step(3);
        m_ready = 1'b1;
        #1;
        chk("t4_done_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        step();
        chk("t4_idle_busy", busy, 0);
        chk("t4_sticky", timeout_err, 1);
        step(2);
        chk("t4_sticky_later", timeout_err, 1);

        // ---------------- 5: reset during WAIT ----------------
        do_reset();
        req_valid = 2'b10;
        m_ready   = 1'b1;
        step();
        m_ready = 1'b0;
        step(2);
        chk("t5_pre_grant_id", grant_id, 1);
        reset   = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_grant_id", grant_id, 0);
        chk("t5_rst_m_addr", m_addr, 0);
        chk("t5_rst_m_wdata", m_wdata, 0);
        chk("t5_rst_m_wstrb", m_wstrb, 0);
        chk("t5_rst_req_ready", req_ready, 0);
        step();
        reset = 1'b0;
        set_req(1, 32'h300, 32'hCAFEF00D, 4'hC);
        req_valid = 2'b10;
        step();
        chk("t5_m_valid", m_valid, 1);
        chk("t5_grant_id", grant_id, 1);
        chk("t5_m_addr", m_addr, 32'h300);
        chk("t5_m_wdata", m_wdata, 32'hCAFEF00D);
        step(2);
        chk("t5_done_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        step();

        // ---------------- 6: withdrawn request ----------------
        do_reset();
        req_valid = 2'b10;
        m_ready   = 1'b1;
        step();
        chk("t6_grant_id", grant_id, 1);
        step();
        m_ready   = 1'b0;
        req_valid = 2'b11;
        step();
        req_valid = 2'b10;
        step();
        m_ready = 1'b1;
        #1;
        chk("t6_done_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        step();
        chk("t6_idle_busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_no_grant", m_valid, 0);
            chk("t6_no_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
